sram_port_arbiter: RTL

//  Shares one single-ported sram slave (1-cycle read latency) between two

---
 rtl/sram_port_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// Two-master arbiter in front of a single-ported, 1-cycle-latency sram.
// Grants are combinational; lock state, last winner and read ownership are registered.
module sram_port_arbiter #(
    parameter int unsigned LEN_ADDR   = 64,
    parameter int unsigned LEN_DATA   = 64,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  m0_req,
    input  logic                  m0_lock,
    input  logic [LEN_ADDR-1:0]   m0_addra,
    input  logic [LEN_DATA-1:0]   m0_dina,
    input  logic [LEN_DATA/8-1:0] m0_wea,
    output logic                  m0_gnt,
    output logic [LEN_DATA-1:0]   m0_douta,
    output logic                  m0_rvalid,
    input  logic                  m1_req,
    input  logic                  m1_lock,
    input  logic [LEN_ADDR-1:0]   m1_addra,
    input  logic [LEN_DATA-1:0]   m1_dina,
    input  logic [LEN_DATA/8-1:0] m1_wea,
    output logic                  m1_gnt,
    output logic [LEN_DATA-1:0]   m1_douta,
    output logic                  m1_rvalid,
    output logic [LEN_ADDR-1:0]   s_addra,
    output logic [LEN_DATA-1:0]   s_dina,
    output logic [LEN_DATA/8-1:0] s_wea,
    output logic                  s_ena,
    input  logic [LEN_DATA-1:0]   s_douta
);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} lock_st_e;
    typedef enum logic [1:0] {RD_NONE, RD_M0, RD_M1} rd_owner_e;

    lock_st_e  lock_st_q, lock_st_d;
    rd_owner_e rd_owner_q, rd_owner_d;
    logic      last_gnt_q, last_gnt_d;
    logic      gnt0, gnt1;

    // Grants are gated by resetn so nothing reaches the sram while reset is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (resetn) begin
            case (lock_st_q)
                IDLE: begin
                    if (m0_req && m1_req) begin
                        if (FIXED_PRIO || last_gnt_q) gnt0 = 1'b1;
                        else                          gnt1 = 1'b1;
                    end else begin
                        gnt0 = m0_req;
                        gnt1 = m1_req;
                    end
                end
                LOCK0:   gnt0 = m0_req;
                LOCK1:   gnt1 = m1_req;
                default: ;
            endcase
        end
    end

    always_comb begin
        lock_st_d = lock_st_q;
        case (lock_st_q)
            IDLE: begin
                if (gnt0 && m0_lock)      lock_st_d = LOCK0;
                else if (gnt1 && m1_lock) lock_st_d = LOCK1;
            end
            LOCK0:   if (!m0_lock) lock_st_d = IDLE;
            LOCK1:   if (!m1_lock) lock_st_d = IDLE;
            default: lock_st_d = IDLE;
        endcase

        last_gnt_d = last_gnt_q;
        if (gnt0)      last_gnt_d = 1'b0;
        else if (gnt1) last_gnt_d = 1'b1;

        rd_owner_d = RD_NONE;
        if (gnt0 && (m0_wea == '0))      rd_owner_d = RD_M0;
        else if (gnt1 && (m1_wea == '0)) rd_owner_d = RD_M1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_st_q  <= IDLE;
            rd_owner_q <= RD_NONE;
            last_gnt_q <= 1'b1;
        end else begin
            lock_st_q  <= lock_st_d;
            rd_owner_q <= rd_owner_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    assign m0_gnt = gnt0;
    assign m1_gnt = gnt1;

    // Address/data default to m0 when idle; only s_ena/s_wea must be quiet.
    assign s_ena   = gnt0 | gnt1;
    assign s_addra = gnt1 ? m1_addra : m0_addra;
    assign s_dina  = gnt1 ? m1_dina  : m0_dina;
    assign s_wea   = gnt0 ? m0_wea : (gnt1 ? m1_wea : '0);

    assign m0_rvalid = (rd_owner_q == RD_M0);
    assign m1_rvalid = (rd_owner_q == RD_M1);
    assign m0_douta  = m0_rvalid ? s_douta : '0;
    assign m1_douta  = m1_rvalid ? s_douta : '0;

endmodule
